// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI responder. Holds the
//                frame-state encoding, the default frame width and the idle
//                level of the serial lines.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Frame state of the responder (explicit 1-bit encoding).
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_slv_state_t;

    localparam int   SPI_WIDTH    = 16;
    localparam logic SPI_IDLE_LVL = 1'b1;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Brings one asynchronous line into the clk domain through a
//                SYNC_FF-deep flop chain, then adds one edge flop to derive
//                single-cycle rise/fall pulses. All flops reset to RST_VAL so
//                an idle bus produces no spurious edge out of reset.
//  Ports       : clk      - system clock
//                rst_n    - asynchronous active-low reset
//                async_in - asynchronous input line
//                sync_out - synchronized level (last chain flop)
//                rise     - 1-clk pulse on a 0->1 transition of sync_out
//                fall     - 1-clk pulse on a 1->0 transition of sync_out
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_FF = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_FF-1:0] r_sync;
    logic               r_prev;

    generate
        if (SYNC_FF == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= RST_VAL;
                end else begin
                    r_sync <= async_in;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= {SYNC_FF{RST_VAL}};
                end else begin
                    r_sync <= {r_sync[SYNC_FF-2:0], async_in};
                end
            end
        end
    endgenerate

    // Edge flop: holds the previous synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= r_sync[SYNC_FF-1];
        end
    end

    assign sync_out = r_sync[SYNC_FF-1];
    assign rise     =  r_sync[SYNC_FF-1] & ~r_prev;
    assign fall     = ~r_sync[SYNC_FF-1] &  r_prev;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_resp.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_resp
//  Description : SPI mode-3 responder. Shifts a WIDTH-bit command in on MOSI
//                (sampled on SCLK rise) while returning a preloaded response
//                on MISO (updated on SCLK fall), MSB first. SCLK, SS_n and
//                MOSI are synchronized to clk before use.
//  Ports       : clk     - system clock (SCLK half-period >= 4 clk)
//                rst_n   - asynchronous active-low reset
//                SCLK    - serial clock from master (idles high)
//                SS_n    - active-low frame select
//                MOSI    - serial data from master
//                MISO    - serial data to master (1 when idle)
//                tx_data - response word for the next frame
//                wrt_tx  - 1-clk pulse, loads tx_data into holding register
//                cmd     - last complete received command
//                cmd_rdy - 1-clk pulse when cmd has been updated
//                busy    - high while a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_resp
    import spi_pkg::*;
#(
    parameter int WIDTH   = SPI_WIDTH,
    parameter int SYNC_FF = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCLK,
    input  logic             SS_n,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt_tx,
    output logic [WIDTH-1:0] cmd,
    output logic             cmd_rdy,
    output logic             busy
);

    localparam int              c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(WIDTH);

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic w_sclk_sync_unused;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_sync_unused;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_mosi_sync;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(SPI_IDLE_LVL)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SCLK),
        .sync_out (w_sclk_sync_unused),
        .rise     (w_sclk_rise),
        .fall     (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(SPI_IDLE_LVL)) u_sync_ss (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SS_n),
        .sync_out (w_ss_sync_unused),
        .rise     (w_ss_rise),
        .fall     (w_ss_fall)
    );

    // MOSI takes the same number of flops as SCLK, so its synchronized level
    // is the bit that was on the pin when SCLK rose.
    spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(SPI_IDLE_LVL)) u_sync_mosi (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (MOSI),
        .sync_out (w_mosi_sync),
        .rise     (w_mosi_rise_unused),
        .fall     (w_mosi_fall_unused)
    );

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    spi_slv_state_t     r_state;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_tx_shift;
    logic [WIDTH-1:0]   r_rx_shift;
    logic [WIDTH-1:0]   r_hold;
    logic               r_miso;
    logic [WIDTH-1:0]   r_cmd;
    logic               r_cmd_rdy;
    logic               r_busy;

    logic               w_take_rise;
    logic [WIDTH-1:0]   w_rx_next;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [WIDTH-1:0]   w_tx_load;

    // Receive-side next values. Computed combinationally so that an SCLK
    // rise landing in the same clk as the SS_n rise is counted before the
    // end-of-frame check. Rises past a full frame are ignored.
    always_comb begin
        w_take_rise = (r_state == SHIFT) && w_sclk_rise && (r_bit_cnt != c_full);
        w_rx_next   = r_rx_shift;
        w_cnt_next  = r_bit_cnt;
        if (w_take_rise) begin
            w_rx_next  = {r_rx_shift[WIDTH-2:0], w_mosi_sync};
            w_cnt_next = r_bit_cnt + 1'b1;
        end
    end

    // A write coinciding with the frame start goes straight to the shifter.
    assign w_tx_load = wrt_tx ? tx_data : r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_hold     <= '0;
            r_miso     <= SPI_IDLE_LVL;
            r_cmd      <= '0;
            r_cmd_rdy  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cmd_rdy <= 1'b0;
            if (wrt_tx) begin
                r_hold <= tx_data;
            end

            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    r_miso <= SPI_IDLE_LVL;
                    if (w_ss_fall) begin
                        r_state    <= SHIFT;
                        r_tx_shift <= w_tx_load;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_miso     <= w_tx_load[WIDTH-1];
                    end
                end

                SHIFT: begin
                    r_rx_shift <= w_rx_next;
                    r_bit_cnt  <= w_cnt_next;
                    if (w_ss_rise) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_miso  <= SPI_IDLE_LVL;
                        // Short frames are dropped without touching cmd.
                        if (w_cnt_next == c_full) begin
                            r_cmd     <= w_rx_next;
                            r_cmd_rdy <= 1'b1;
                        end
                    end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                        // The leading fall of a frame does not shift: the MSB
                        // must stay on MISO until the master samples it.
                        r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                        r_miso     <= r_tx_shift[WIDTH-2];
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign MISO    = r_miso;
    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;
    assign busy    = r_busy;

endmodule : spi_slave_resp
`default_nettype wire

// File: tb/tb_spi_slave_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_resp
//  Description : Self-checking bench for spi_slave_resp. A behavioural mode-3
//                master (16-clk SCLK half-period) runs directed frames;
//                expected commands and read-back words go into queues and a
//                monitor compares them whenever cmd_rdy or the master's
//                read-complete strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_resp;

    localparam int c_width = 16;
    localparam int c_sync  = 2;
    localparam int c_half  = 16;

    logic               clk;
    logic               rst_n;
    logic               SCLK;
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [c_width-1:0] tx_data;
    logic               wrt_tx;
    logic [c_width-1:0] cmd;
    logic               cmd_rdy;
    logic               busy;

    // Master read-back strobe, generated by the bench's master model.
    logic               rd_valid;
    logic [c_width-1:0] rd_word;

    logic [c_width-1:0] exp_cmd_q[$];
    logic [c_width-1:0] exp_rd_q[$];

    int n_checks;
    int n_errors;

    spi_slave_resp #(.WIDTH(c_width), .SYNC_FF(c_sync)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SCLK    (SCLK),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .tx_data (tx_data),
        .wrt_tx  (wrt_tx),
        .cmd     (cmd),
        .cmd_rdy (cmd_rdy),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [c_width-1:0] act, logic [c_width-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // All stimulus changes 2 ns after the rising edge.
    task automatic wait_clk();
        @(posedge clk);
        #2;
    endtask

    task automatic do_wrt(input logic [c_width-1:0] d);
        tx_data = d;
        wrt_tx  = 1'b1;
        wait_clk();
        wrt_tx  = 1'b0;
    endtask

    // One master frame: nrise SCLK cycles, optional SS_n release, optional
    // wrt_tx pulse timed to coincide with the synchronized SS_n fall.
    task automatic xfer(input logic [c_width-1:0] word, input int nrise,
                        input bit end_frame, input bit wr_at_fall,
                        input logic [c_width-1:0] wr_data);
        logic [c_width-1:0] rd;
        rd = '0;
        if (end_frame && nrise == c_width) exp_cmd_q.push_back(word);
        SS_n = 1'b0;
        if (wr_at_fall) begin
            repeat (c_sync) wait_clk();
            do_wrt(wr_data);
        end
        repeat (8) wait_clk();
        chk("busy_in_frame", {15'd0, busy}, 16'd1);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b0;
            MOSI = word[c_width-1-i];
            repeat (c_half) wait_clk();
            SCLK = 1'b1;
            rd   = {rd[c_width-2:0], MISO};
            repeat (c_half) wait_clk();
        end
        MOSI = 1'b1;
        if (end_frame) begin
            repeat (8) wait_clk();
            SS_n = 1'b1;
            repeat (12) wait_clk();
            if (nrise == c_width) begin
                rd_word  = rd;
                rd_valid = 1'b1;
                wait_clk();
                rd_valid = 1'b0;
            end
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (cmd_rdy) begin
            if (exp_cmd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_cmd_rdy: got cmd %h expected no pulse", cmd);
            end else begin
                chk("cmd", cmd, exp_cmd_q.pop_front());
            end
        end
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rd: got %h expected nothing", rd_word);
            end else begin
                chk("master_rd", rd_word, exp_rd_q.pop_front());
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        SCLK     = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b1;
        tx_data  = '0;
        wrt_tx   = 1'b0;
        rd_valid = 1'b0;
        rd_word  = '0;

        // Reset state
        repeat (5) wait_clk();
        chk("rst_miso",    {15'd0, MISO},    16'd1);
        chk("rst_cmd",     cmd,              16'h0000);
        chk("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("rst_busy",    {15'd0, busy},    16'd0);
        rst_n = 1'b1;
        repeat (5) wait_clk();

        // T1: basic frame
        do_wrt(16'hA5C3);
        exp_rd_q.push_back(16'hA5C3);
        xfer(16'h1234, 16, 1'b1, 1'b0, 16'h0);

        // T2: back-to-back frames, single-bit and all-ones patterns
        do_wrt(16'h8000);
        exp_rd_q.push_back(16'h8000);
        xfer(16'h0001, 16, 1'b1, 1'b0, 16'h0);
        do_wrt(16'h7FFF);
        exp_rd_q.push_back(16'h7FFF);
        xfer(16'hFFFF, 16, 1'b1, 1'b0, 16'h0);

        // T3: holding-register write during a frame affects only the next one
        do_wrt(16'h1111);
        exp_rd_q.push_back(16'h1111);
        exp_rd_q.push_back(16'hBEEF);
        fork
            xfer(16'h0F0F, 16, 1'b1, 1'b0, 16'h0);
            begin
                repeat (200) wait_clk();
                do_wrt(16'hBEEF);
            end
        join
        xfer(16'hF0F0, 16, 1'b1, 1'b0, 16'h0);

        // T4: aborted frame after 9 rises
        xfer(16'h3C3C, 9, 1'b1, 1'b0, 16'h0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_cmd",  cmd,           16'hF0F0);
        chk("abort_miso", {15'd0, MISO}, 16'd1);
        do_wrt(16'h2222);
        exp_rd_q.push_back(16'h2222);
        xfer(16'h5A5A, 16, 1'b1, 1'b0, 16'h0);

        // T5: reset in the middle of a frame
        do_wrt(16'h9999);
        xfer(16'hAAAA, 7, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        repeat (4) wait_clk();
        chk("midrst_miso",    {15'd0, MISO},    16'd1);
        chk("midrst_cmd",     cmd,              16'h0000);
        chk("midrst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
        chk("midrst_busy",    {15'd0, busy},    16'd0);
        rst_n = 1'b1;
        repeat (6) wait_clk();
        exp_rd_q.push_back(16'h0000);   // holding register was cleared by reset
        xfer(16'hC0DE, 16, 1'b1, 1'b0, 16'h0);

        // T6: wrt_tx in the same clk as the detected SS_n fall
        do_wrt(16'hDEAD);
        chk("idle_miso_pre", {15'd0, MISO}, 16'd1);
        exp_rd_q.push_back(16'h4321);
        xfer(16'h6789, 16, 1'b1, 1'b1, 16'h4321);
        chk("idle_miso_post", {15'd0, MISO}, 16'd1);
        chk("idle_busy_post", {15'd0, busy}, 16'd0);

        // Every queued expectation must have been consumed.
        repeat (20) wait_clk();
        chk("cmd_q_left", 16'(exp_cmd_q.size()), 16'd0);
        chk("rd_q_left",  16'(exp_rd_q.size()),  16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_spi_slave_resp
`default_nettype wire
